// File: rtl/bp_pkg.sv
// Shared types and constants for the local-history branch predictor.
// PHT entries are 2-bit saturating direction counters.
package bp_pkg;

  typedef logic [1:0] pht_cnt_t;

  localparam pht_cnt_t SNT = 2'b00;
  localparam pht_cnt_t WNT = 2'b01;
  localparam pht_cnt_t WT  = 2'b10;
  localparam pht_cnt_t ST  = 2'b11;

  localparam pht_cnt_t PHT_RESET = WNT;

endpackage

// File: rtl/sat_cnt2.sv
// Two-bit saturating up/down counter step, purely combinational.
// Counts toward ST on taken and toward SNT on not-taken.
module sat_cnt2
  import bp_pkg::*;
(
  input  logic [1:0] cnt_in,
  input  logic       taken,
  output logic [1:0] cnt_out
);

  always_comb begin
    cnt_out = cnt_in;
    if (taken) begin
      if (cnt_in != ST) cnt_out = cnt_in + 2'd1;
    end else begin
      if (cnt_in != SNT) cnt_out = cnt_in - 2'd1;
    end
  end

endmodule

// File: rtl/bht_predictor.sv
// Two-level local-history branch predictor: per-pc history table indexing a shared PHT.
// Predicts in Fetch, trains and counts on the Memory-stage branch resolution.
module bht_predictor
  import bp_pkg::*;
#(
  parameter int BHT_BITS  = 6,
  parameter int BHR_WIDTH = 6,
  parameter int PHT_BITS  = 8,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          pc,
  input  logic                 pcsrcM,
  input  logic                 pcsrcPM,
  input  logic                 branchM,
  input  logic [31:0]          pcM,
  output logic                 pbranchF,
  output logic                 pmis,
  output logic                 flushD,
  output logic                 flushE,
  output logic                 flushM,
  output logic [CNT_WIDTH-1:0] perf_branches,
  output logic [CNT_WIDTH-1:0] perf_mispredicts
);

  localparam int BHT_ENTRIES = 2 ** BHT_BITS;
  localparam int PHT_ENTRIES = 2 ** PHT_BITS;
  localparam int IDX_TOP     = ((BHT_BITS > PHT_BITS) ? BHT_BITS : PHT_BITS) + 2;

  logic [BHR_WIDTH-1:0] r_bht [BHT_ENTRIES];
  pht_cnt_t             r_pht [PHT_ENTRIES];
  logic [CNT_WIDTH-1:0] r_perf_branches;
  logic [CNT_WIDTH-1:0] r_perf_mispredicts;

  logic [BHT_BITS-1:0]  w_f_bht_idx;
  logic [BHR_WIDTH-1:0] w_f_hist;
  logic [PHT_BITS-1:0]  w_f_pht_idx;
  pht_cnt_t             w_f_cnt;

  logic [BHT_BITS-1:0]  w_m_bht_idx;
  logic [BHR_WIDTH-1:0] w_m_hist;
  logic [PHT_BITS-1:0]  w_m_pht_idx;
  pht_cnt_t             w_m_cnt;
  pht_cnt_t             w_m_cnt_next;
  logic [BHR_WIDTH-1:0] w_m_hist_next;

  logic                 w_pmis;
  logic                 w_unused;

  // Fetch-side lookup: history is zero-extended into the low PHT index bits.
  assign w_f_bht_idx = pc[BHT_BITS+1:2];
  assign w_f_hist    = r_bht[w_f_bht_idx];
  assign w_f_pht_idx = pc[PHT_BITS+1:2] ^ PHT_BITS'(w_f_hist);
  assign w_f_cnt     = r_pht[w_f_pht_idx];
  assign pbranchF    = w_f_cnt[1];

  // Memory-side lookup uses the history as it stands now, not as it stood at predict time.
  assign w_m_bht_idx = pcM[BHT_BITS+1:2];
  assign w_m_hist    = r_bht[w_m_bht_idx];
  assign w_m_pht_idx = pcM[PHT_BITS+1:2] ^ PHT_BITS'(w_m_hist);
  assign w_m_cnt     = r_pht[w_m_pht_idx];

  generate
    if (BHR_WIDTH > 1) begin : g_shift
      assign w_m_hist_next = {w_m_hist[BHR_WIDTH-2:0], pcsrcM};
    end else begin : g_single
      assign w_m_hist_next = pcsrcM;
    end
  endgenerate

  sat_cnt2 u_sat_cnt2 (
    .cnt_in  (w_m_cnt),
    .taken   (pcsrcM),
    .cnt_out (w_m_cnt_next)
  );

  assign w_pmis = branchM & (pcsrcM ^ pcsrcPM);
  assign pmis   = w_pmis;
  assign flushD = w_pmis;
  assign flushE = w_pmis;
  assign flushM = w_pmis;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) r_bht[i] <= '0;
      for (int j = 0; j < PHT_ENTRIES; j++) r_pht[j] <= PHT_RESET;
    end else if (branchM) begin
      r_bht[w_m_bht_idx] <= w_m_hist_next;
      r_pht[w_m_pht_idx] <= w_m_cnt_next;
    end
  end

  // Counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf_branches    <= '0;
      r_perf_mispredicts <= '0;
    end else if (branchM) begin
      if (r_perf_branches != '1) r_perf_branches <= r_perf_branches + CNT_WIDTH'(1);
      if (w_pmis && (r_perf_mispredicts != '1))
        r_perf_mispredicts <= r_perf_mispredicts + CNT_WIDTH'(1);
    end
  end

  assign perf_branches    = r_perf_branches;
  assign perf_mispredicts = r_perf_mispredicts;

  assign w_unused = ^{pc[31:IDX_TOP], pc[1:0], pcM[31:IDX_TOP], pcM[1:0]};

endmodule

// File: tb/tb_bht_predictor.sv
// Self-checking bench for bht_predictor: behavioural model plus expected-value queue.
module tb_bht_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc, pcM;
  logic        pcsrcM, pcsrcPM, branchM;
  logic        pbranchF, pmis, flushD, flushE, flushM;
  logic [31:0] perf_branches, perf_mispredicts;
  logic        s_pbranchF, s_pmis, s_flushD, s_flushE, s_flushM;
  logic [2:0]  s_branches, s_mispredicts;

  int checks = 0;
  int errors = 0;

  bht_predictor dut (
    .clk(clk), .rst(rst), .pc(pc), .pcsrcM(pcsrcM), .pcsrcPM(pcsrcPM),
    .branchM(branchM), .pcM(pcM), .pbranchF(pbranchF), .pmis(pmis),
    .flushD(flushD), .flushE(flushE), .flushM(flushM),
    .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts)
  );

  // Narrow-counter instance on the same inputs, to reach counter saturation.
  bht_predictor #(.CNT_WIDTH(3)) dut_s (
    .clk(clk), .rst(rst), .pc(pc), .pcsrcM(pcsrcM), .pcsrcPM(pcsrcPM),
    .branchM(branchM), .pcM(pcM), .pbranchF(s_pbranchF), .pmis(s_pmis),
    .flushD(s_flushD), .flushE(s_flushE), .flushM(s_flushM),
    .perf_branches(s_branches), .perf_mispredicts(s_mispredicts)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pbr;
    logic        pmis;
    logic [31:0] br;
    logic [31:0] mis;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  logic [5:0]  m_bht [64];
  logic [1:0]  m_pht [256];
  logic [31:0] m_br, m_mis;

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_bht[i] = 6'd0;
    for (int i = 0; i < 256; i++) m_pht[i] = 2'b01;
    m_br  = 0;
    m_mis = 0;
    q.delete();
  endtask

  function automatic logic m_pred(input logic [31:0] p);
    logic [5:0] h;
    logic [7:0] i;
    h = m_bht[p[7:2]];
    i = p[9:2] ^ {2'b00, h};
    return m_pht[i][1];
  endfunction

  // Drive one cycle at the falling edge, queue the expected outputs, advance the model.
  task automatic drive(input logic [31:0] p, input logic b, input logic [31:0] pm,
                       input logic t, input logic pt);
    exp_t       x;
    logic [5:0] hm;
    logic [7:0] i;
    logic [1:0] c;
    @(negedge clk);
    pc = p; branchM = b; pcM = pm; pcsrcM = t; pcsrcPM = pt;
    x.pbr  = m_pred(p);
    x.pmis = b & (t ^ pt);
    x.br   = m_br;
    x.mis  = m_mis;
    q.push_back(x);
    if (b) begin
      hm = m_bht[pm[7:2]];
      i  = pm[9:2] ^ {2'b00, hm};
      c  = m_pht[i];
      if (t) c = (c == 2'b11) ? c : c + 2'd1;
      else   c = (c == 2'b00) ? c : c - 2'd1;
      m_pht[i] = c;
      m_bht[pm[7:2]] = {hm[4:0], t};
      m_br = m_br + 1;
      if (t ^ pt) m_mis = m_mis + 1;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; pc = 32'h0040_0010; pcM = 32'h0; branchM = 1'b0; pcsrcM = 1'b0; pcsrcPM = 1'b0;
    model_reset();
    #3;
    checks++; if (pbranchF !== 1'b0) begin errors++; $display("FAIL reset_pbranchF got %b exp 0", pbranchF); end
    checks++; if (perf_branches !== 32'd0) begin errors++; $display("FAIL reset_branches got %0d exp 0", perf_branches); end
    checks++; if (perf_mispredicts !== 32'd0) begin errors++; $display("FAIL reset_mispredicts got %0d exp 0", perf_mispredicts); end
    checks++; if (pmis !== 1'b0) begin errors++; $display("FAIL reset_pmis got %b exp 0", pmis); end
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_mispredict();
    drive(32'h0040_0010, 1'b1, 32'h100, 1'b1, 1'b0);
    e = q.pop_front();
    checks++; if (pmis !== 1'b1) begin errors++; $display("FAIL mis_pmis got %b exp 1", pmis); end
    checks++; if ({flushD, flushE, flushM} !== 3'b111) begin errors++; $display("FAIL mis_flush got %b exp 111", {flushD, flushE, flushM}); end
    checks++; if (pbranchF !== e.pbr) begin errors++; $display("FAIL mis_pbranchF got %b exp %b", pbranchF, e.pbr); end
    drive(32'h100, 1'b0, 32'h100, 1'b0, 1'b0);
    e = q.pop_front();
    checks++; if (dut.r_bht[0] !== 6'b000001) begin errors++; $display("FAIL mis_bht0 got %b exp 000001", dut.r_bht[0]); end
    checks++; if (dut.r_pht[8'h40] !== 2'b10) begin errors++; $display("FAIL mis_pht40 got %b exp 10", dut.r_pht[8'h40]); end
    checks++; if (perf_branches !== 32'd1) begin errors++; $display("FAIL mis_branches got %0d exp 1", perf_branches); end
    checks++; if (perf_mispredicts !== 32'd1) begin errors++; $display("FAIL mis_mispredicts got %0d exp 1", perf_mispredicts); end
    checks++; if (pbranchF !== e.pbr) begin errors++; $display("FAIL mis_pred_after got %b exp %b", pbranchF, e.pbr); end
  endtask

  task automatic test_no_branch();
    for (int k = 0; k < 3; k++) begin
      drive(32'h100, 1'b0, 32'h100, 1'b1, 1'b0);
      e = q.pop_front();
      checks++; if ({pmis, flushD, flushE, flushM} !== 4'b0000) begin errors++; $display("FAIL nobr_pmis_flush got %b exp 0000", {pmis, flushD, flushE, flushM}); end
      checks++; if (perf_branches !== e.br || perf_mispredicts !== e.mis) begin errors++; $display("FAIL nobr_counters got %0d/%0d exp %0d/%0d", perf_branches, perf_mispredicts, e.br, e.mis); end
    end
    checks++; if (dut.r_bht[0] !== 6'b000001) begin errors++; $display("FAIL nobr_bht0 got %b exp 000001", dut.r_bht[0]); end
  endtask

  task automatic test_train_taken();
    for (int k = 0; k < 8; k++) begin
      drive(32'h100, 1'b1, 32'h100, 1'b1, m_pred(32'h100));
      e = q.pop_front();
      checks++; if (pmis !== e.pmis || pbranchF !== e.pbr) begin errors++; $display("FAIL train_step%0d got pmis %b pbr %b exp %b %b", k, pmis, pbranchF, e.pmis, e.pbr); end
    end
    drive(32'h100, 1'b0, 32'h0, 1'b0, 1'b0);
    e = q.pop_front();
    checks++; if (dut.r_bht[0] !== 6'b111111) begin errors++; $display("FAIL train_bht0 got %b exp 111111", dut.r_bht[0]); end
    checks++; if (dut.r_pht[8'h7F] !== 2'b11) begin errors++; $display("FAIL train_pht7f got %b exp 11", dut.r_pht[8'h7F]); end
    checks++; if (pbranchF !== 1'b1) begin errors++; $display("FAIL train_pbranchF got %b exp 1", pbranchF); end
    checks++; if (perf_branches !== e.br) begin errors++; $display("FAIL train_branches got %0d exp %0d", perf_branches, e.br); end
  endtask

  task automatic test_collision();
    drive(32'h100, 1'b1, 32'h100, 1'b0, 1'b1);
    e = q.pop_front();
    checks++; if (pbranchF !== 1'b1) begin errors++; $display("FAIL coll_old_pbranchF got %b exp 1", pbranchF); end
    checks++; if (pmis !== 1'b1) begin errors++; $display("FAIL coll_pmis got %b exp 1", pmis); end
    drive(32'h100, 1'b0, 32'h0, 1'b0, 1'b0);
    e = q.pop_front();
    checks++; if (pbranchF !== 1'b0) begin errors++; $display("FAIL coll_new_pbranchF got %b exp 0", pbranchF); end
    checks++; if (pbranchF !== e.pbr) begin errors++; $display("FAIL coll_model got %b exp %b", pbranchF, e.pbr); end
  endtask

  task automatic test_saturate_down();
    for (int k = 0; k < 4; k++) begin
      drive(32'h304, 1'b1, 32'h304, 1'b0, m_pred(32'h304));
      e = q.pop_front();
      checks++; if (pmis !== e.pmis || pbranchF !== e.pbr) begin errors++; $display("FAIL satdn_step%0d got pmis %b pbr %b exp %b %b", k, pmis, pbranchF, e.pmis, e.pbr); end
    end
    drive(32'h304, 1'b0, 32'h0, 1'b0, 1'b0);
    e = q.pop_front();
    checks++; if (dut.r_pht[8'hC1] !== 2'b00) begin errors++; $display("FAIL satdn_phtc1 got %b exp 00", dut.r_pht[8'hC1]); end
  endtask

  task automatic test_alternate();
    logic [31:0] mis_mark;
    mis_mark = 0;
    for (int k = 0; k < 64; k++) begin
      if (k == 48) mis_mark = perf_mispredicts;
      drive(32'h200, 1'b1, 32'h200, (k % 2) == 0, m_pred(32'h200));
      e = q.pop_front();
      checks++; if (pmis !== e.pmis || pbranchF !== e.pbr || perf_mispredicts !== e.mis) begin errors++; $display("FAIL alt_step%0d got pmis %b pbr %b mis %0d exp %b %b %0d", k, pmis, pbranchF, perf_mispredicts, e.pmis, e.pbr, e.mis); end
      if (k >= 48) begin
        checks++; if (pmis !== 1'b0) begin errors++; $display("FAIL alt_late_pmis%0d got %b exp 0", k, pmis); end
      end
    end
    drive(32'h200, 1'b0, 32'h0, 1'b0, 1'b0);
    e = q.pop_front();
    checks++; if (perf_mispredicts - mis_mark !== 32'd0) begin errors++; $display("FAIL alt_last16 got %0d exp 0", perf_mispredicts - mis_mark); end
    checks++; if (perf_branches !== e.br) begin errors++; $display("FAIL alt_branches got %0d exp %0d", perf_branches, e.br); end
    checks++; if (s_branches !== 3'd7) begin errors++; $display("FAIL sat_branches got %0d exp 7", s_branches); end
    checks++; if (s_mispredicts !== ((e.mis > 7) ? 3'd7 : e.mis[2:0])) begin errors++; $display("FAIL sat_mispredicts got %0d exp %0d", s_mispredicts, (e.mis > 7) ? 7 : e.mis); end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    pc = 32'h100; branchM = 1'b0;
    #2 rst = 1'b0;
    #1;
    model_reset();
    checks++; if (perf_branches !== 32'd0 || perf_mispredicts !== 32'd0) begin errors++; $display("FAIL arst_counters got %0d/%0d exp 0/0", perf_branches, perf_mispredicts); end
    checks++; if (pbranchF !== 1'b0) begin errors++; $display("FAIL arst_pbranchF got %b exp 0", pbranchF); end
    checks++; if (dut.r_bht[0] !== 6'd0) begin errors++; $display("FAIL arst_bht0 got %b exp 0", dut.r_bht[0]); end
    checks++; if (dut.r_pht[8'h80] !== 2'b01) begin errors++; $display("FAIL arst_pht80 got %b exp 01", dut.r_pht[8'h80]); end
    #1 rst = 1'b1;
    drive(32'h100, 1'b1, 32'h100, 1'b1, 1'b1);
    e = q.pop_front();
    drive(32'h100, 1'b0, 32'h0, 1'b0, 1'b0);
    e = q.pop_front();
    checks++; if (perf_branches !== 32'd1 || perf_mispredicts !== 32'd0) begin errors++; $display("FAIL arst_resume got %0d/%0d exp 1/0", perf_branches, perf_mispredicts); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_mispredict();
    test_no_branch();
    test_train_taken();
    test_collision();
    test_saturate_down();
    test_alternate();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
